// File: rtl/rx_deserializer_if.sv
// rtl/rx_deserializer_if.sv - serial line and aligned-symbol signals of the receive deserializer
// Ports:
//   RX_P, RX_N     serial line legs (driven by the line side)
//   SYMBOL[9:0]    aligned symbol, bit 9 = first received bit
//   SYMBOL_VALID   one-cycle strobe for SYMBOL
//   RXVALID        lane locked
//   COMMA_DET      one-cycle strobe, SYMBOL is K28.5
//   RXELECIDLE     electrical idle detected
// Modports: master = deserializer, slave = line driver / symbol consumer.
interface rx_deserializer_if;
  logic       RX_P;
  logic       RX_N;
  logic [9:0] SYMBOL;
  logic       SYMBOL_VALID;
  logic       RXVALID;
  logic       COMMA_DET;
  logic       RXELECIDLE;

  modport master (
    input  RX_P, RX_N,
    output SYMBOL, SYMBOL_VALID, RXVALID, COMMA_DET, RXELECIDLE
  );

  modport slave (
    output RX_P, RX_N,
    input  SYMBOL, SYMBOL_VALID, RXVALID, COMMA_DET, RXELECIDLE
  );
endinterface

// File: rtl/rx_deserializer.sv
// rtl/rx_deserializer.sv - K28.5 comma alignment and 10-bit symbol deserialization
// Ports:
//   TRANSCLK  serial bit clock, rising edge
//   RESET_N   asynchronous active-low reset
//   rx        rx_deserializer_if.master (line in, aligned symbols out)
// Optional feature: define RX_ELECIDLE_EN to enable electrical-idle detection.
module rx_deserializer #(
  parameter int LOCK_COMMAS = 3,
  parameter int LOSS_COMMAS = 4,
  parameter int IDLE_CYCLES = 16
) (
  input logic               TRANSCLK,
  input logic               RESET_N,
  rx_deserializer_if.master rx
);
  localparam logic [9:0] K28_5_RDN = 10'b0011111010;
  localparam logic [9:0] K28_5_RDP = 10'b1100000101;
  localparam logic [3:0] LOCK_N    = 4'(LOCK_COMMAS);
  localparam logic [3:0] LOSS_N    = 4'(LOSS_COMMAS);

  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

  state_t     state, state_nxt;
  logic [9:0] window;
  logic [3:0] phase, phase_nxt;
  logic [3:0] good_cnt, good_nxt, good_inc;
  logic [3:0] bad_cnt, bad_nxt, bad_inc;
  logic [9:0] symbol_q, symbol_nxt;
  logic       symbol_valid_q, symbol_valid_nxt;
  logic       comma_q, comma_nxt;
  logic       comma_match, boundary, idle_force;

  assign comma_match = (window == K28_5_RDN) || (window == K28_5_RDP);
  assign boundary    = (phase == 4'd9);
  assign good_inc    = (good_cnt == 4'hF) ? good_cnt : good_cnt + 4'd1;
  assign bad_inc     = (bad_cnt == 4'hF) ? bad_cnt : bad_cnt + 4'd1;

`ifdef RX_ELECIDLE_EN
  localparam logic [7:0] IDLE_N = 8'(IDLE_CYCLES);
  logic [7:0] idle_cnt, idle_nxt;
  logic       elecidle_q;
  logic       line_eq;

  assign line_eq = (rx.RX_P == rx.RX_N);

  always_comb begin
    idle_nxt = 8'd0;
    if (line_eq)
      idle_nxt = (idle_cnt == 8'hFF) ? idle_cnt : idle_cnt + 8'd1;
  end

  // Idle holds the lane in HUNT for as long as the legs stay equal.
  assign idle_force    = line_eq && (idle_nxt >= IDLE_N);
  assign rx.RXELECIDLE = elecidle_q;

  always_ff @(posedge TRANSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      idle_cnt   <= 8'd0;
      elecidle_q <= 1'b0;
    end else begin
      idle_cnt   <= idle_nxt;
      elecidle_q <= idle_force;
    end
  end
`else
  logic unused_rx_n;
  assign unused_rx_n   = rx.RX_N;
  assign idle_force    = 1'b0;
  assign rx.RXELECIDLE = 1'b0;
`endif

  always_comb begin
    state_nxt        = state;
    phase_nxt        = boundary ? 4'd0 : phase + 4'd1;
    good_nxt         = good_cnt;
    bad_nxt          = bad_cnt;
    symbol_nxt       = symbol_q;
    symbol_valid_nxt = 1'b0;
    comma_nxt        = 1'b0;
    unique case (state)
      HUNT: begin
        // The bit just shifted in closes a symbol: restart phase from here.
        if (comma_match) begin
          phase_nxt = 4'd0;
          good_nxt  = 4'd1;
          bad_nxt   = 4'd0;
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        if (comma_match) begin
          if (boundary) begin
            good_nxt = good_inc;
            if (good_inc >= LOCK_N) begin
              state_nxt = LOCKED;
              bad_nxt   = 4'd0;
            end
          end else begin
            phase_nxt = 4'd0;
            good_nxt  = 4'd1;
          end
        end
      end
      LOCKED: begin
        if (boundary) begin
          symbol_nxt       = window;
          symbol_valid_nxt = 1'b1;
          comma_nxt        = comma_match;
          if (comma_match)
            bad_nxt = 4'd0;
        end else if (comma_match) begin
          // Keep delivering on the old phase until enough misaligned commas are seen.
          bad_nxt = bad_inc;
          if (bad_inc >= LOSS_N) begin
            state_nxt = HUNT;
            good_nxt  = 4'd0;
            bad_nxt   = 4'd0;
          end
        end
      end
      default: state_nxt = HUNT;
    endcase
    if (idle_force) begin
      state_nxt        = HUNT;
      phase_nxt        = 4'd0;
      good_nxt         = 4'd0;
      bad_nxt          = 4'd0;
      symbol_valid_nxt = 1'b0;
      comma_nxt        = 1'b0;
    end
  end

  always_ff @(posedge TRANSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state          <= HUNT;
      window         <= 10'd0;
      phase          <= 4'd0;
      good_cnt       <= 4'd0;
      bad_cnt        <= 4'd0;
      symbol_q       <= 10'h000;
      symbol_valid_q <= 1'b0;
      comma_q        <= 1'b0;
    end else begin
      state          <= state_nxt;
      window         <= {window[8:0], rx.RX_P};
      phase          <= phase_nxt;
      good_cnt       <= good_nxt;
      bad_cnt        <= bad_nxt;
      symbol_q       <= symbol_nxt;
      symbol_valid_q <= symbol_valid_nxt;
      comma_q        <= comma_nxt;
    end
  end

  assign rx.SYMBOL       = symbol_q;
  assign rx.SYMBOL_VALID = symbol_valid_q;
  assign rx.RXVALID      = (state == LOCKED);
  assign rx.COMMA_DET    = comma_q;
endmodule
